// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: state codes,
// datapath select codes and the base-ISA major opcodes.
package mc_control_fsm_pkg;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   localparam logic [1:0] SRC_A_PC   = 2'b00;
   localparam logic [1:0] SRC_A_RS1  = 2'b01;
   localparam logic [1:0] SRC_A_ZERO = 2'b10;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_BRANCH = 2'b01;
   localparam logic [1:0] ALU_FUNCT  = 2'b10;

   localparam logic [1:0] WD_ALUOUT  = 2'b00;
   localparam logic [1:0] WD_MDR     = 2'b01;
   localparam logic [1:0] WD_PC4     = 2'b10;

   localparam logic [1:0] PC_SRC_PC4    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   function automatic logic is_known_opcode(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_JAL,
         OP_IMM, OP_RTYPE, OP_LUI, OP_AUIPC, OP_SYSTEM: return 1'b1;
         default:                                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_control_fsm_retire_counter.sv
// Retired-instruction counter: increments on enable, wraps modulo 2^CNT_WIDTH,
// cleared asynchronously by an active-low clear.
module retire_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 clr_n,
   input  logic                 enable,
   output logic [CNT_WIDTH-1:0] count
);

   // NOTE: sequential state is only ever assigned with <=, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit: sequences IF/ID/EX/MEM/WB per opcode, handshakes
// with a shared memory via mem_ready, counts retirements and halts on ECALL x17==HALT_ID.
module mc_control_fsm
   import mc_control_fsm_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int CNT_WIDTH = 32,
   parameter int HALT_ID   = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           opcode,
   input  logic [XLEN-1:0]      x17_val,
   input  logic                 alu_bcond,
   input  logic                 mem_ready,
   output logic                 ir_write,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 i_or_d,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           alu_op,
   output logic [1:0]           wd_sel,
   output logic                 reg_write,
   output logic                 pc_write,
   output logic [1:0]           pc_source,
   output logic                 is_halted,
   output logic                 illegal_op,
   output logic [CNT_WIDTH-1:0] retired_count,
   output logic [2:0]           state_o
);

   state_t state;
   state_t next_state;
   logic   is_ecall;
   logic   halt_call;
   logic   unknown_op;
   logic   halt_entry;
   logic   retire_en;

   assign is_ecall   = (opcode == OP_SYSTEM);
   assign halt_call  = is_ecall && (x17_val == XLEN'(HALT_ID));
   assign unknown_op = !is_known_opcode(opcode);
   assign halt_entry = (state != S_HALT) && (next_state == S_HALT);
   assign retire_en  = pc_write || halt_entry;
   assign state_o    = state;

   // Outputs are a pure decode of state and inputs; gating on reset makes the
   // strobes drop the moment reset falls, even mid-access.
   always_comb begin
      // NOTE: every output gets a default before the case so no path can infer a latch.
      next_state = state;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RS2;
      alu_op     = ALU_ADD;
      wd_sel     = WD_ALUOUT;
      reg_write  = 1'b0;
      pc_write   = 1'b0;
      pc_source  = PC_SRC_PC4;
      if (reset) begin
         case (state)
            S_IF: begin
               mem_read = 1'b1;
               if (mem_ready) begin
                  ir_write   = 1'b1;
                  next_state = S_ID;
               end
            end
            S_ID: begin
               // ALUOut <= PC + imm here so JAL and taken branches find their target ready.
               alu_src_b = SRC_B_IMM;
               if (halt_call) begin
                  next_state = S_HALT;
               end else if (is_ecall || unknown_op) begin
                  pc_write   = 1'b1;
                  next_state = S_IF;
               end else if (opcode == OP_JAL) begin
                  next_state = S_WB;
               end else begin
                  next_state = S_EX;
               end
            end
            S_EX: begin
               next_state = S_WB;
               case (opcode)
                  OP_RTYPE: begin
                     alu_src_a = SRC_A_RS1;
                     alu_op    = ALU_FUNCT;
                  end
                  OP_IMM: begin
                     alu_src_a = SRC_A_RS1;
                     alu_src_b = SRC_B_IMM;
                     alu_op    = ALU_FUNCT;
                  end
                  OP_LOAD, OP_STORE: begin
                     alu_src_a  = SRC_A_RS1;
                     alu_src_b  = SRC_B_IMM;
                     next_state = S_MEM;
                  end
                  OP_JALR: begin
                     alu_src_a = SRC_A_RS1;
                     alu_src_b = SRC_B_IMM;
                  end
                  OP_LUI: begin
                     alu_src_a = SRC_A_ZERO;
                     alu_src_b = SRC_B_IMM;
                  end
                  OP_AUIPC: begin
                     alu_src_b = SRC_B_IMM;
                  end
                  OP_BRANCH: begin
                     alu_src_a  = SRC_A_RS1;
                     alu_op     = ALU_BRANCH;
                     pc_write   = 1'b1;
                     pc_source  = alu_bcond ? PC_SRC_ALUOUT : PC_SRC_PC4;
                     next_state = S_IF;
                  end
                  default: next_state = S_IF;
               endcase
            end
            S_MEM: begin
               i_or_d    = 1'b1;
               mem_read  = (opcode == OP_LOAD);
               mem_write = (opcode == OP_STORE);
               if (mem_ready) begin
                  if (opcode == OP_LOAD) begin
                     next_state = S_WB;
                  end else begin
                     pc_write   = (opcode == OP_STORE);
                     next_state = S_IF;
                  end
               end
            end
            S_WB: begin
               reg_write  = 1'b1;
               pc_write   = 1'b1;
               next_state = S_IF;
               if (opcode == OP_LOAD) begin
                  wd_sel = WD_MDR;
               end else if (opcode == OP_JAL || opcode == OP_JALR) begin
                  wd_sel    = WD_PC4;
                  pc_source = PC_SRC_ALUOUT;
               end
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = S_IF;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IF;
         is_halted  <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         state <= next_state;
         if (halt_entry) begin
            is_halted <= 1'b1;
         end
         if (state == S_ID && unknown_op) begin
            illegal_op <= 1'b1;
         end
      end
   end

   retire_counter #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_retire_counter (
      .clk    (clk),
      .clr_n  (reset),
      .enable (retire_en),
      .count  (retired_count)
   );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed instruction scenarios plus a randomized instruction
// stream, each compared against a transaction-level model of latency and strobe counts.
module tb_mc_control_fsm;

   localparam int XLEN      = 32;
   localparam int CNT_WIDTH = 32;
   localparam int HALT_ID   = 10;

   localparam logic [6:0] RV_LOAD   = 7'h03;
   localparam logic [6:0] RV_STORE  = 7'h23;
   localparam logic [6:0] RV_BRANCH = 7'h63;
   localparam logic [6:0] RV_JALR   = 7'h67;
   localparam logic [6:0] RV_JAL    = 7'h6F;
   localparam logic [6:0] RV_IMM    = 7'h13;
   localparam logic [6:0] RV_R      = 7'h33;
   localparam logic [6:0] RV_LUI    = 7'h37;
   localparam logic [6:0] RV_AUIPC  = 7'h17;
   localparam logic [6:0] RV_SYSTEM = 7'h73;

   localparam logic [2:0] ST_IF   = 3'd0;
   localparam logic [2:0] ST_HALT = 3'd5;

   typedef enum int {
      C_R, C_IMM, C_LUI, C_AUIPC, C_LOAD, C_STORE, C_BRANCH,
      C_JAL, C_JALR, C_ECALL, C_ILLEGAL, C_HALT
   } cls_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [6:0]           opcode;
   logic [XLEN-1:0]      x17_val;
   logic                 alu_bcond;
   logic                 mem_ready;
   logic                 ir_write, mem_read, mem_write, i_or_d;
   logic [1:0]           alu_src_a, alu_src_b, alu_op, wd_sel;
   logic                 reg_write, pc_write;
   logic [1:0]           pc_source;
   logic                 is_halted, illegal_op;
   logic [CNT_WIDTH-1:0] retired_count;
   logic [2:0]           state_o;

   int                   checks   = 0;
   int                   failures = 0;
   logic [CNT_WIDTH-1:0] exp_count;
   logic                 exp_illegal;
   logic                 exp_halted;
   logic [6:0]           bad_ops [4] = '{7'h7F, 7'h00, 7'h0B, 7'h5B};

   always #5 clk = ~clk;

   mc_control_fsm #(
      .XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH), .HALT_ID(HALT_ID)
   ) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .x17_val(x17_val),
      .alu_bcond(alu_bcond), .mem_ready(mem_ready), .ir_write(ir_write),
      .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .wd_sel(wd_sel), .reg_write(reg_write), .pc_write(pc_write),
      .pc_source(pc_source), .is_halted(is_halted), .illegal_op(illegal_op),
      .retired_count(retired_count), .state_o(state_o)
   );

   wire [15:0] ctrl_vec = {ir_write, mem_read, mem_write, i_or_d, alu_src_a, alu_src_b,
                           alu_op, wd_sel, reg_write, pc_write, pc_source};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one instruction through the FSM, acting as the memory, and compares
   // latency and per-instruction strobe totals with what the ISA rules predict.
   task automatic run_instr(input cls_t c, input int fw, input int mw, input logic bcond,
                            input logic [31:0] x17, input logic [6:0] bad_op);
      logic [6:0] op;
      int   lat, e_mr, e_mw, e_iod, e_rw, e_pw, e_wd, e_src, e_a, e_b, e_op;
      logic has_ex, chk_op;
      logic [2:0] e_state;
      int   n_ir, n_mr, n_mw, n_iod, n_rw, n_pw;
      int   s_wd, s_src, id_a, id_b, id_op, ex_a, ex_b, ex_op;
      int   fleft, mleft;
      string nm;

      nm = c.name();
      e_mr = fw + 1; e_mw = 0; e_iod = 0; e_rw = 0; e_pw = 1; e_wd = 0; e_src = 0;
      has_ex = 1'b0; chk_op = 1'b1; e_a = 0; e_b = 0; e_op = 0; e_state = ST_IF;
      lat = fw + 4; op = RV_R;
      case (c)
         C_R:      begin op = RV_R;     e_rw = 1; has_ex = 1; e_a = 1; e_b = 0; e_op = 2; end
         C_IMM:    begin op = RV_IMM;   e_rw = 1; has_ex = 1; e_a = 1; e_b = 1; e_op = 2; end
         C_LUI:    begin op = RV_LUI;   e_rw = 1; has_ex = 1; e_a = 2; e_b = 1; chk_op = 0; end
         C_AUIPC:  begin op = RV_AUIPC; e_rw = 1; has_ex = 1; e_a = 0; e_b = 1; chk_op = 0; end
         C_LOAD: begin
            op = RV_LOAD; lat = fw + mw + 5; e_mr = fw + mw + 2; e_iod = mw + 1;
            e_rw = 1; e_wd = 1; has_ex = 1; e_a = 1; e_b = 1; e_op = 0;
         end
         C_STORE: begin
            op = RV_STORE; lat = fw + mw + 4; e_mw = mw + 1; e_iod = mw + 1;
            has_ex = 1; e_a = 1; e_b = 1; e_op = 0;
         end
         C_BRANCH: begin
            op = RV_BRANCH; lat = fw + 3; e_src = bcond ? 1 : 0;
            has_ex = 1; e_a = 1; e_b = 0; e_op = 1;
         end
         C_JAL:     begin op = RV_JAL;  lat = fw + 3; e_rw = 1; e_wd = 2; e_src = 1; end
         C_JALR: begin
            op = RV_JALR; e_rw = 1; e_wd = 2; e_src = 1; has_ex = 1; e_a = 1; e_b = 1; e_op = 0;
         end
         C_ECALL:   begin op = RV_SYSTEM; lat = fw + 2; end
         C_ILLEGAL: begin op = bad_op;    lat = fw + 2; exp_illegal = 1'b1; end
         C_HALT: begin
            op = RV_SYSTEM; lat = fw + 2; e_pw = 0; e_state = ST_HALT; exp_halted = 1'b1;
         end
         default: ;
      endcase
      exp_count = exp_count + 1'b1;

      n_ir = 0; n_mr = 0; n_mw = 0; n_iod = 0; n_rw = 0; n_pw = 0;
      s_wd = -1; s_src = -1; id_a = -1; id_b = -1; id_op = -1; ex_a = -1; ex_b = -1; ex_op = -1;
      fleft = fw; mleft = mw;
      alu_bcond = bcond;
      for (int cyc = 0; cyc < lat; cyc++) begin
         @(negedge clk);
         opcode  = (cyc <= fw) ? 7'($urandom) : op;
         x17_val = (cyc <= fw) ? $urandom : x17;
         #1;
         if ((mem_read || mem_write) && !i_or_d) begin
            mem_ready = (fleft == 0);
            if (fleft > 0) fleft--;
         end else if (mem_read || mem_write) begin
            mem_ready = (mleft == 0);
            if (mleft > 0) mleft--;
         end else begin
            mem_ready = 1'($urandom);
         end
         #1;
         n_ir += int'(ir_write);  n_mr += int'(mem_read);  n_mw += int'(mem_write);
         n_iod += int'(i_or_d);   n_rw += int'(reg_write); n_pw += int'(pc_write);
         if (reg_write) s_wd = int'(wd_sel);
         if (pc_write)  s_src = int'(pc_source);
         if (cyc == fw + 1) begin id_a = int'(alu_src_a); id_b = int'(alu_src_b); id_op = int'(alu_op); end
         if (cyc == fw + 2) begin ex_a = int'(alu_src_a); ex_b = int'(alu_src_b); ex_op = int'(alu_op); end
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      check({nm, ".end_state"}, state_o, e_state);
      check({nm, ".retired"}, retired_count, exp_count);
      check({nm, ".ir_write_cycles"}, n_ir, 1);
      check({nm, ".mem_read_cycles"}, n_mr, e_mr);
      check({nm, ".mem_write_cycles"}, n_mw, e_mw);
      check({nm, ".i_or_d_cycles"}, n_iod, e_iod);
      check({nm, ".reg_write_cycles"}, n_rw, e_rw);
      check({nm, ".pc_write_cycles"}, n_pw, e_pw);
      if (e_rw != 0) check({nm, ".wd_sel"}, s_wd, e_wd);
      if (e_pw != 0) check({nm, ".pc_source"}, s_src, e_src);
      check({nm, ".id_alu"}, {id_a, id_b, id_op}, {32'd0, 32'd1, 32'd0});
      if (has_ex) begin
         check({nm, ".ex_src_a"}, ex_a, e_a);
         check({nm, ".ex_src_b"}, ex_b, e_b);
         if (chk_op) check({nm, ".ex_alu_op"}, ex_op, e_op);
      end
      check({nm, ".illegal_op"}, illegal_op, exp_illegal);
      check({nm, ".is_halted"}, is_halted, exp_halted);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cls_t        c;
      logic [31:0] x17;

      reset = 1'b0; opcode = '0; x17_val = '0; alu_bcond = 1'b0; mem_ready = 1'b0;
      exp_count = '0; exp_illegal = 1'b0; exp_halted = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.state", state_o, ST_IF);
      check("reset.ctrl", ctrl_vec, 16'h0);
      check("reset.count", retired_count, 0);
      check("reset.flags", {is_halted, illegal_op}, 2'b00);
      @(negedge clk);
      reset = 1'b1;

      // Directed scenarios: ADDI, LW with waits, both branch outcomes, ECALL, illegal.
      run_instr(C_IMM,     0, 0, 1'b0, 32'd10, 7'h00);
      run_instr(C_LOAD,    0, 3, 1'b0, 32'd0,  7'h00);
      run_instr(C_BRANCH,  0, 0, 1'b1, 32'd0,  7'h00);
      run_instr(C_BRANCH,  0, 0, 1'b0, 32'd0,  7'h00);
      run_instr(C_ECALL,   0, 0, 1'b0, 32'd5,  7'h00);
      run_instr(C_ILLEGAL, 0, 0, 1'b0, 32'd0,  7'h7F);
      run_instr(C_JAL,     2, 0, 1'b1, 32'd10, 7'h00);
      run_instr(C_STORE,   1, 2, 1'b0, 32'd0,  7'h00);

      for (int i = 0; i < 60; i++) begin
         c   = cls_t'($urandom_range(0, 10));
         x17 = 32'($urandom_range(0, 20));
         if (c == C_ECALL && x17 == 32'd10) x17 = 32'd11;
         run_instr(c, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), x17,
                   bad_ops[$urandom_range(0, 3)]);
      end

      // Reset dropped while a store waits in the memory phase.
      @(negedge clk);
      opcode = RV_STORE; mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("sw_abort.pre_mem_write", {mem_write, i_or_d}, 2'b11);
      reset = 1'b0;
      #1;
      check("sw_abort.mem_write_drop", {mem_write, i_or_d}, 2'b00);
      check("sw_abort.ctrl", ctrl_vec, 16'h0);
      check("sw_abort.count", retired_count, 0);
      @(negedge clk);
      reset = 1'b1;
      exp_count = '0; exp_illegal = 1'b0; exp_halted = 1'b0;
      @(posedge clk);
      #1;
      check("sw_abort.state_after", state_o, ST_IF);
      check("sw_abort.count_after", retired_count, 0);
      run_instr(C_R, 0, 0, 1'b0, 32'd10, 7'h00);

      // Halting ECALL, then the absorbing state under random stimulus.
      run_instr(C_HALT, 1, 0, 1'b0, 32'd10, 7'h00);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         opcode = 7'($urandom); x17_val = $urandom; alu_bcond = 1'($urandom);
         mem_ready = 1'($urandom);
         #1;
         check("halt.ctrl", ctrl_vec, 16'h0);
         check("halt.state", state_o, ST_HALT);
      end
      @(posedge clk);
      #1;
      check("halt.count_stable", retired_count, exp_count);
      check("halt.sticky", is_halted, 1'b1);

      @(negedge clk);
      reset = 1'b0; mem_ready = 1'b0;
      #1;
      check("halt_exit.state", state_o, ST_IF);
      check("halt_exit.flags", {is_halted, illegal_op}, 2'b00);
      check("halt_exit.count", retired_count, 0);
      @(negedge clk);
      reset = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
